// File: rtl/n_channel_stream_mux.sv
// n_channel_stream_mux: packet-locked N:1 stream mux with fixed or round-robin arbitration.
// Optional macro NCSM_BEAT_COUNT_EN adds a 16-bit output beat counter.
module n_channel_stream_mux #(
    parameter int N_INPUTS    = 8,
    parameter int INPUT_WIDTH = 22,
    parameter int SEL_WIDTH   = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_INPUTS*INPUT_WIDTH-1:0] in_data,
    input  logic [N_INPUTS-1:0]             in_valid,
    input  logic [N_INPUTS-1:0]             in_last,
    output logic [N_INPUTS-1:0]             in_ready,
    input  logic                            mode,
    input  logic [SEL_WIDTH-1:0]            sel,
    output logic [INPUT_WIDTH-1:0]          out_data,
    output logic                            out_valid,
    output logic                            out_last,
    output logic [SEL_WIDTH-1:0]            out_chan,
    input  logic                            out_ready,
`ifdef NCSM_BEAT_COUNT_EN
    output logic [15:0]                     beat_count,
`endif
    output logic                            busy
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_nxt;
    logic [SEL_WIDTH-1:0] grant, ptr, pick;
    logic [N_INPUTS-1:0] rot, grant_hot;
    logic found, take, fire, g_valid, g_last;
    logic [INPUT_WIDTH-1:0] g_data;
    int off;
    // Rotating in_valid by ptr turns the round-robin search into a lowest-set-bit search.
    always_comb begin
        rot = N_INPUTS'({in_valid, in_valid} >> ptr);
        off = 0;
        for (int i = N_INPUTS - 1; i >= 0; i--)
            if (rot[i]) off = i;
        found = mode ? |rot : |(in_valid & (N_INPUTS'(1) << sel));
        pick = mode ? SEL_WIDTH'((int'(ptr) + off) % N_INPUTS) : sel;
    end
    always_comb begin
        grant_hot = N_INPUTS'(1) << grant;
        g_valid = |(in_valid & grant_hot);
        g_last = |(in_last & grant_hot);
        g_data = INPUT_WIDTH'(in_data >> (int'(grant) * INPUT_WIDTH));
        busy = state == LOCKED;
        take = busy && (!out_valid || out_ready);
        in_ready = take ? grant_hot : '0;
        fire = take && g_valid;
        state_nxt = state;
        if (state == IDLE && found) state_nxt = LOCKED;
        if (fire && g_last) state_nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            ptr <= '0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_data <= '0;
            out_chan <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) grant <= pick;
            if (fire && g_last) ptr <= SEL_WIDTH'((int'(grant) + 1) % N_INPUTS);
            if (fire) begin
                out_valid <= 1'b1;
                out_last <= g_last;
                out_data <= g_data;
                out_chan <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
`ifdef NCSM_BEAT_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) beat_count <= '0;
        else if (out_valid && out_ready) beat_count <= beat_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_n_channel_stream_mux.sv
// tb_n_channel_stream_mux: directed stimulus with a scoreboard queue checked by an output monitor.
module tb_n_channel_stream_mux;
    localparam int N = 8, W = 22, S = 5;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0] in_valid = '0, in_last = '0, in_ready;
    logic mode = 1'b0, out_ready = 1'b0;
    logic [S-1:0] sel = '0, out_chan;
    logic [W-1:0] out_data;
    logic out_valid, out_last, busy;
`ifdef NCSM_BEAT_COUNT_EN
    logic [15:0] beat_count;
    int beats_seen = 0;
`endif

    n_channel_stream_mux #(.N_INPUTS(N), .INPUT_WIDTH(W), .SEL_WIDTH(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_chan(out_chan), .out_ready(out_ready),
`ifdef NCSM_BEAT_COUNT_EN
        .beat_count(beat_count),
`endif
        .busy(busy));

    always #5 clk = ~clk;

    typedef struct packed {logic [W-1:0] d; logic l;} beat_t;
    typedef struct packed {logic [W-1:0] d; logic l; logic [S-1:0] c;} exp_t;
    beat_t src[N][$];
    exp_t exq[$];
    int pop_cyc[$];
    int total = 0, bad = 0, cyc = 0;
    logic [N-1:0] fire = '0;

    always @(posedge clk) cyc++;

    // Monitor: handshakes seen at negedge complete at the following posedge.
    always @(negedge clk) begin
        exp_t e;
        fire = in_valid & in_ready;
        if (out_valid && out_ready) begin
            total++;
`ifdef NCSM_BEAT_COUNT_EN
            beats_seen++;
`endif
            if (exq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: got data=%h last=%b chan=%0d, want no beat", out_data, out_last, out_chan);
            end else begin
                e = exq.pop_front();
                pop_cyc.push_back(cyc);
                if ({out_data, out_last, out_chan} !== {e.d, e.l, e.c}) begin
                    bad++;
                    $display("FAIL beat: got data=%h last=%b chan=%0d, want data=%h last=%b chan=%0d",
                             out_data, out_last, out_chan, e.d, e.l, e.c);
                end
            end
        end
    end

    // Per-channel sources present the head of their queue until it is accepted.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (fire[k] && src[k].size() > 0) void'(src[k].pop_front());
            in_valid[k] = src[k].size() > 0;
            if (src[k].size() > 0) begin
                in_data[k*W +: W] = src[k][0].d;
                in_last[k] = src[k][0].l;
            end
        end
        fire = '0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic put(input int ch, input logic [W-1:0] d, input logic l, input bit expect_out);
        exp_t e;
        src[ch].push_back('{d: d, l: l});
        e.d = d; e.l = l; e.c = S'(ch);
        if (expect_out) exq.push_back(e);
    endtask

    task automatic flush();
        for (int k = 0; k < N; k++) src[k].delete();
        exq.delete();
        pop_cyc.delete();
    endtask

    task automatic wait_size(input int sz, input int lim);
        int n = 0;
        while (exq.size() > sz && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_scoreboard", 64'(exq.size() <= sz), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        flush();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic chk_gaps(input string nm, input int cnt, input int gap);
        chk({nm, "_count"}, 64'(pop_cyc.size()), 64'(cnt));
        for (int i = 1; i < pop_cyc.size(); i++)
            chk({nm, "_gap"}, 64'(pop_cyc[i] - pop_cyc[i-1]), 64'(gap));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_chan", 64'(out_chan), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Fixed selection, 3-beat packet on channel 2 at full throughput.
        mode = 1'b0; sel = 5'd2;
        put(2, 22'h11, 1'b0, 1'b1);
        put(2, 22'h22, 1'b0, 1'b1);
        put(2, 22'h33, 1'b1, 1'b1);
        wait_size(2, 20);
        chk("t_fixed_busy_locked", 64'(busy), 64'd1);
        wait_size(0, 20);
        @(posedge clk); #1;
        chk("t_fixed_busy_after", 64'(busy), 64'd0);
        chk_gaps("t_fixed", 3, 1);

        // Round-robin over all channels with single-beat packets, wrapping back to 0.
        do_reset();
        mode = 1'b1;
        for (int k = 0; k < N; k++) put(k, 22'(32'h100 + k), 1'b1, 1'b1);
        put(0, 22'h200, 1'b1, 1'b1);
        wait_size(0, 60);
        chk_gaps("t_rr", 9, 2);

        // Backpressure mid-packet on channel 1; sel/mode changes while locked are ignored.
        @(posedge clk); #1;
        mode = 1'b0; sel = 5'd1;
        put(1, 22'hA1, 1'b0, 1'b1);
        put(1, 22'hA2, 1'b0, 1'b1);
        put(1, 22'hA3, 1'b0, 1'b1);
        put(1, 22'hA4, 1'b1, 1'b1);
        wait_size(3, 20);
        out_ready = 1'b0; sel = 5'd6; mode = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t_bp_valid", 64'(out_valid), 64'd1);
            chk("t_bp_data", 64'(out_data), 64'(exq.size() > 0 ? exq[0].d : '1));
            chk("t_bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_size(0, 20);
        @(posedge clk); #1;
        chk("t_bp_busy_after", 64'(busy), 64'd0);

        // Out-of-range selector never grants.
        do_reset();
        mode = 1'b0; sel = 5'd9;
        for (int k = 0; k < N; k++) put(k, 22'(32'h300 + k), 1'b1, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk("t_oor_in_ready", 64'(in_ready), 64'd0);
            chk("t_oor_out_valid", 64'(out_valid), 64'd0);
            chk("t_oor_busy", 64'(busy), 64'd0);
        end

        // Asynchronous reset during beat 2 of 4, then a clean new packet.
        do_reset();
        mode = 1'b0; sel = 5'd3;
        put(3, 22'hC1, 1'b0, 1'b1);
        put(3, 22'hC2, 1'b0, 1'b1);
        put(3, 22'hC3, 1'b0, 1'b1);
        put(3, 22'hC4, 1'b1, 1'b1);
        wait_size(3, 20);
        #2;
        rst_n = 1'b0;
        flush();
        #1;
        chk("t_ar_out_valid", 64'(out_valid), 64'd0);
        chk("t_ar_out_data", 64'(out_data), 64'd0);
        chk("t_ar_out_last", 64'(out_last), 64'd0);
        chk("t_ar_out_chan", 64'(out_chan), 64'd0);
        chk("t_ar_busy", 64'(busy), 64'd0);
        chk("t_ar_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        put(3, 22'hD1, 1'b0, 1'b1);
        put(3, 22'hD2, 1'b1, 1'b1);
        wait_size(0, 20);
        chk_gaps("t_ar_new", 2, 1);
`ifdef NCSM_BEAT_COUNT_EN
        @(posedge clk); #1;
        chk("beat_count", 64'(beat_count), 64'(beats_seen % 65536));
`endif
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
